fetch_sequencer: RTL and testbench

//   Sequences the instruction ROM: owns the program counter, drives the ROM address, runs one program per Start.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_sequencer_pc_next_calc.sv | 34 +++
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_fetch_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Imported by pc_next_calc and fetch_sequencer.
package fetch_pkg;

    localparam int IW_DEF = 8;
    localparam int PC_MAX = (1 << IW_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Combinational next-PC selection: stall, halt, absolute and relative branch, increment.
// The wrap flag is raised only by a plain increment rolling over the top address.
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int IW = IW_DEF
) (
    input  logic [IW-1:0] pc,
    input  logic          stall,
    input  logic          halt_req,
    input  logic          branch_abs,
    input  logic [IW-1:0] target,
    input  logic          branch_rel,
    input  logic [IW-1:0] offset,
    output logic [IW-1:0] pc_next,
    output logic          wrap
);

    always_comb begin
        pc_next = pc;
        wrap    = 1'b0;
        if (stall || halt_req) begin
            pc_next = pc;
        end else if (branch_abs) begin
            pc_next = target;
        end else if (branch_rel) begin
            pc_next = pc + offset;
        end else begin
            pc_next = pc + 1'b1;
            wrap    = (pc == {IW{1'b1}});
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and IDLE/RUN/DONE sequencer for the instruction ROM.
// Optional saturating perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [IW-1:0]    StartAddr,
    input  logic             Stall,
    input  logic             HaltReq,
    input  logic             BranchAbs,
    input  logic [IW-1:0]    Target,
    input  logic             BranchRel,
    input  logic [IW-1:0]    Offset,
    output logic [IW-1:0]    InstAddress,
    output logic             InstValid,
    output logic             Busy,
    output logic             Done,
    output logic             Wrapped,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstCnt
);

    fetch_state_t  state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic          wrapped_q, wrapped_d;
    logic [IW-1:0] pc_calc;
    logic          wrap_calc;
    logic          start_acc;

    pc_next_calc #(
        .IW(IW)
    ) u_pc_next (
        .pc        (pc_q),
        .stall     (Stall),
        .halt_req  (HaltReq),
        .branch_abs(BranchAbs),
        .target    (Target),
        .branch_rel(BranchRel),
        .offset    (Offset),
        .pc_next   (pc_calc),
        .wrap      (wrap_calc)
    );

    assign start_acc = Start && (state_q != RUN);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrapped_d = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = StartAddr;
                end
            end
            RUN: begin
                pc_d      = pc_calc;
                wrapped_d = wrap_calc;
                if (!Stall && HaltReq) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign InstAddress = pc_q;
    assign Busy        = (state_q == RUN);
    assign InstValid   = (state_q == RUN);
    assign Done        = (state_q == DONE);
    assign Wrapped     = wrapped_q;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;

    // Counters saturate rather than roll so long programs never read small.
    always_comb begin
        cyc_cnt_d  = cyc_cnt_q;
        inst_cnt_d = inst_cnt_q;
        if (start_acc) begin
            cyc_cnt_d  = '0;
            inst_cnt_d = '0;
        end else if (state_q == RUN) begin
            if (cyc_cnt_q != {CNT_W{1'b1}}) begin
                cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
            if (!Stall && (inst_cnt_q != {CNT_W{1'b1}})) begin
                inst_cnt_d = inst_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cyc_cnt_q  <= '0;
            inst_cnt_q <= '0;
        end else begin
            cyc_cnt_q  <= cyc_cnt_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign CycleCnt = cyc_cnt_q;
    assign InstCnt  = inst_cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign CycleCnt = '0;
    assign InstCnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scoreboard of expected ROM addresses
// plus inline status and perf-counter checks, one task per scenario.
module tb_fetch_sequencer;

    localparam int IW    = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic [IW-1:0]    StartAddr = '0;
    logic             Stall = 1'b0;
    logic             HaltReq = 1'b0;
    logic             BranchAbs = 1'b0;
    logic [IW-1:0]    Target = '0;
    logic             BranchRel = 1'b0;
    logic [IW-1:0]    Offset = '0;
    logic [IW-1:0]    InstAddress;
    logic             InstValid;
    logic             Busy;
    logic             Done;
    logic             Wrapped;
    logic [CNT_W-1:0] CycleCnt;
    logic [CNT_W-1:0] InstCnt;

    int errors = 0;
    int checks = 0;
    logic [IW-1:0] sb[$];
    logic [IW-1:0] exp_a;
    logic [3:0]    st;

`ifdef FETCH_PERF_CNT_EN
    localparam logic [CNT_W-1:0] EXP_CYC  = 16'd10;
    localparam logic [CNT_W-1:0] EXP_INST = 16'd7;
`else
    localparam logic [CNT_W-1:0] EXP_CYC  = 16'd0;
    localparam logic [CNT_W-1:0] EXP_INST = 16'd0;
`endif

    fetch_sequencer #(
        .IW   (IW),
        .CNT_W(CNT_W)
    ) dut (
        .Clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .HaltReq    (HaltReq),
        .BranchAbs  (BranchAbs),
        .Target     (Target),
        .BranchRel  (BranchRel),
        .Offset     (Offset),
        .InstAddress(InstAddress),
        .InstValid  (InstValid),
        .Busy       (Busy),
        .Done       (Done),
        .Wrapped    (Wrapped),
        .CycleCnt   (CycleCnt),
        .InstCnt    (InstCnt)
    );

    always #5 clk = ~clk;

    assign st = {Busy, Done, InstValid, Wrapped};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if (st !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got %b want 0000", st);
        end
        checks++;
        if (InstAddress !== 8'h00) begin
            errors++;
            $display("FAIL reset_pc: got %h want 00", InstAddress);
        end
        checks++;
        if ({CycleCnt, InstCnt} !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", CycleCnt, InstCnt);
        end
        Reset = 1'b0;
    endtask

    task automatic test_sequential();
        Start = 1'b1;
        StartAddr = 8'h10;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'h10 + 8'(i));
            tick();
            Start = 1'b0;
            exp_a = sb.pop_front();
            checks++;
            if (InstAddress !== exp_a) begin
                errors++;
                $display("FAIL seq_pc[%0d]: got %h want %h", i, InstAddress, exp_a);
            end
            checks++;
            if (st !== 4'b1010) begin
                errors++;
                $display("FAIL seq_status[%0d]: got %b want 1010", i, st);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0] kind [3];
        logic [7:0] tgt [3];
        logic [7:0] off [3];
        logic [7:0] res [3];
        kind = '{3'b001, 3'b010, 3'b011};
        tgt  = '{8'h20, 8'h00, 8'h80};
        off  = '{8'h00, 8'hFE, 8'h05};
        res  = '{8'h20, 8'h1E, 8'h80};
        for (int i = 0; i < 3; i++) begin
            BranchAbs = kind[i][0];
            BranchRel = kind[i][1];
            Target = tgt[i];
            Offset = off[i];
            sb.push_back(res[i]);
            tick();
            exp_a = sb.pop_front();
            checks++;
            if (InstAddress !== exp_a) begin
                errors++;
                $display("FAIL branch_pc[%0d]: got %h want %h", i, InstAddress, exp_a);
            end
        end
        BranchAbs = 1'b0;
        BranchRel = 1'b0;
    endtask

    task automatic test_stall_halt();
        BranchAbs = 1'b1;
        Target = 8'h30;
        sb.push_back(8'h30);
        tick();
        BranchAbs = 1'b0;
        void'(sb.pop_front());
        Stall = 1'b1;
        HaltReq = 1'b1;
        BranchAbs = 1'b1;
        Target = 8'h99;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                Stall = 1'b0;
                BranchAbs = 1'b0;
            end
            if (i == 4) HaltReq = 1'b0;
            sb.push_back(8'h30);
            tick();
            exp_a = sb.pop_front();
            checks++;
            if (InstAddress !== exp_a) begin
                errors++;
                $display("FAIL stall_pc[%0d]: got %h want %h", i, InstAddress, exp_a);
            end
            checks++;
            if (st !== ((i < 3) ? 4'b1010 : 4'b0100)) begin
                errors++;
                $display("FAIL stall_status[%0d]: got %b want %b", i, st,
                         (i < 3) ? 4'b1010 : 4'b0100);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] res [5];
        logic [3:0] sts [5];
        res = '{8'hFF, 8'h00, 8'h01, 8'hFF, 8'h00};
        sts = '{4'b1010, 4'b1011, 4'b1010, 4'b1010, 4'b1010};
        for (int i = 0; i < 5; i++) begin
            Start = (i == 0);
            StartAddr = 8'hFF;
            BranchAbs = (i == 3);
            Target = 8'hFF;
            BranchRel = (i == 4);
            Offset = 8'h01;
            sb.push_back(res[i]);
            tick();
            exp_a = sb.pop_front();
            checks++;
            if (InstAddress !== exp_a) begin
                errors++;
                $display("FAIL wrap_pc[%0d]: got %h want %h", i, InstAddress, exp_a);
            end
            checks++;
            if (st !== sts[i]) begin
                errors++;
                $display("FAIL wrap_status[%0d]: got %b want %b", i, st, sts[i]);
            end
        end
        Start = 1'b0;
        BranchAbs = 1'b0;
        BranchRel = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        BranchAbs = 1'b1;
        Target = 8'h44;
        sb.push_back(8'h44);
        tick();
        BranchAbs = 1'b0;
        exp_a = sb.pop_front();
        checks++;
        if (InstAddress !== exp_a) begin
            errors++;
            $display("FAIL midrst_pre: got %h want %h", InstAddress, exp_a);
        end
        Reset = 1'b1;
        sb.push_back(8'h00);
        tick();
        Reset = 1'b0;
        exp_a = sb.pop_front();
        checks++;
        if (InstAddress !== exp_a) begin
            errors++;
            $display("FAIL midrst_pc: got %h want %h", InstAddress, exp_a);
        end
        checks++;
        if (st !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_status: got %b want 0000", st);
        end
        tick();
        checks++;
        if (st !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_idle_hold: got %b want 0000", st);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] res [6];
        logic [3:0] sts [6];
        logic       s_in [6];
        logic [7:0] a_in [6];
        logic       h_in [6];
        res  = '{8'h40, 8'h41, 8'h41, 8'h05, 8'h05, 8'h07};
        sts  = '{4'b1010, 4'b1010, 4'b0100, 4'b1010, 4'b0100, 4'b1010};
        s_in = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        a_in = '{8'h40, 8'h90, 8'h90, 8'h05, 8'h07, 8'h07};
        h_in = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            Start = s_in[i];
            StartAddr = a_in[i];
            HaltReq = h_in[i];
            sb.push_back(res[i]);
            tick();
            exp_a = sb.pop_front();
            checks++;
            if (InstAddress !== exp_a) begin
                errors++;
                $display("FAIL b2b_pc[%0d]: got %h want %h", i, InstAddress, exp_a);
            end
            checks++;
            if (st !== sts[i]) begin
                errors++;
                $display("FAIL b2b_status[%0d]: got %b want %b", i, st, sts[i]);
            end
        end
        Start = 1'b0;
        HaltReq = 1'b1;
        tick();
        HaltReq = 1'b0;
    endtask

    task automatic test_perf();
        logic [7:0] pc_m;
        Start = 1'b1;
        StartAddr = 8'h00;
        tick();
        Start = 1'b0;
        checks++;
        if ({CycleCnt, InstCnt} !== 32'h0) begin
            errors++;
            $display("FAIL perf_clear: got %h/%h want 0/0", CycleCnt, InstCnt);
        end
        pc_m = 8'h00;
        for (int i = 0; i < 10; i++) begin
            Stall = (i == 2) || (i == 4) || (i == 6);
            HaltReq = (i == 9);
            if (!Stall && !HaltReq) pc_m = pc_m + 8'h01;
            sb.push_back(pc_m);
            tick();
            exp_a = sb.pop_front();
            checks++;
            if (InstAddress !== exp_a) begin
                errors++;
                $display("FAIL perf_pc[%0d]: got %h want %h", i, InstAddress, exp_a);
            end
        end
        Stall = 1'b0;
        HaltReq = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (st !== 4'b0100) begin
                errors++;
                $display("FAIL perf_done[%0d]: got %b want 0100", k, st);
            end
            checks++;
            if (CycleCnt !== EXP_CYC) begin
                errors++;
                $display("FAIL perf_cycles[%0d]: got %0d want %0d", k, CycleCnt, EXP_CYC);
            end
            checks++;
            if (InstCnt !== EXP_INST) begin
                errors++;
                $display("FAIL perf_insts[%0d]: got %0d want %0d", k, InstCnt, EXP_INST);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_halt();
        test_wrap();
        test_reset_mid_run();
        test_back_to_back();
        test_perf();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
